// File: rtl/sy_up.sv
// ============================================================================
// Module      : sy_up
// Description : Synchronous binary up-counter built from toggle stages, with
//               asynchronous clear and a programmable wrap modulus.
//               Optional terminal-count output enabled by macro SYUP_TC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sy_up #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count_out
`ifdef SYUP_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);
    localparam bit               c_NPOT = (MODULUS < (2 ** WIDTH));

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_toggle;
    logic             w_wrap;

    assign w_wrap    = (r_count == c_LAST);
    assign count_out = r_count;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_lsb
                assign w_toggle[i] = 1'b1;
            end else begin : g_upper
                assign w_toggle[i] = &r_count[i-1:0];
            end

            if (c_NPOT) begin : g_clear
                // Truncated modulus: the wrap compare overrides the toggle.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_count[i] <= 1'b0;
                    end else if (w_wrap) begin
                        r_count[i] <= 1'b0;
                    end else if (w_toggle[i]) begin
                        r_count[i] <= ~r_count[i];
                    end
                end
            end else begin : g_natural
                // Full binary range: natural rollover already yields zero.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_count[i] <= 1'b0;
                    end else if (w_toggle[i]) begin
                        r_count[i] <= ~r_count[i];
                    end
                end
            end
        end
    endgenerate

`ifdef SYUP_TC_EN
    assign tc = w_wrap & ~reset;
`else
    logic w_unused;
    assign w_unused = w_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sy_up.sv
// ============================================================================
// Module      : tb_sy_up
// Description : Self-checking bench for sy_up (default and modulus-6 builds)
//               against an edge-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sy_up;

    logic       clk;
    logic       reset;
    logic [2:0] count8;
    logic [2:0] count6;
`ifdef SYUP_TC_EN
    logic       tc8;
    logic       tc6;
`endif

    int n_cmp;
    int n_err;
    int edges;

    sy_up #(.WIDTH(3)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .count_out (count8)
`ifdef SYUP_TC_EN
        ,
        .tc        (tc8)
`endif
    );

    sy_up #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .count_out (count6)
`ifdef SYUP_TC_EN
        ,
        .tc        (tc6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each counter is the number of un-reset edges modulo its length.
    task automatic check_all(input string tag);
        int e8, e6;
        e8 = reset ? 0 : edges % 8;
        e6 = reset ? 0 : edges % 6;
        check({tag, "_cnt8"}, int'(count8), e8);
        check({tag, "_cnt6"}, int'(count6), e6);
        check({tag, "_cnt6_range"}, int'(count6 < 3'd6), 1);
`ifdef SYUP_TC_EN
        check({tag, "_tc8"}, int'(tc8), int'(!reset && (e8 == 7)));
        check({tag, "_tc6"}, int'(tc6), int'(!reset && (e6 == 5)));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) edges++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag, input int hold);
        #2;
        reset = 1'b1;
        #1;
        edges = 0;
        check_all({tag, "_immediate"});
        for (int k = 0; k < hold; k++) step({tag, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        edges = 0;
        reset = 1'b1;

        // Power-up reset with the clock running.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_all("por");
        end
        reset = 1'b0;

        // Release, count and at least three full wraps.
        for (int k = 0; k < 30; k++) step("count");

        // Clear mid-count at value 5.
        while (count8 != 3'd5) step("seek5");
        async_reset("mid5", 2);
        for (int k = 0; k < 10; k++) step("resume");

        // Random run lengths and random reset pulses.
        for (int it = 0; it < 25; it++) begin
            int run;
            run = int'($urandom_range(1, 20));
            for (int k = 0; k < run; k++) step("rand_run");
            async_reset("rand_rst", int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 12; k++) step("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
